// File: rtl/adi2axis_pkg.sv
// rtl/adi2axis_pkg.sv - shared state type, width helpers and null-beat constant for adi2axis_pkt
package adi2axis_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_TERM
  } state_t;

  function automatic int calc_dw(input int num_ch, input int ch_bytes);
    return num_ch * ch_bytes * 8;
  endfunction

  function automatic int calc_sw(input int num_ch, input int ch_bytes);
    return num_ch * ch_bytes;
  endfunction

  // Wide enough for any sane beat width; users slice the low DW bits.
  localparam int NULL_MAX_W = 1024;
  localparam logic [NULL_MAX_W-1:0] NULL_BEAT = '0;

endpackage

// File: rtl/adi2axis_fifo.sv
// rtl/adi2axis_fifo.sv - single-clock first-word-fall-through buffer between ADC capture and AXIS output
module adi2axis_fifo #(
  parameter int DW      = 64,
  parameter int FIFO_AW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          empty
);

  logic [DW-1:0]    r_mem [2**FIFO_AW];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign dout    = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= din;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adi2axis_pkt.sv
// rtl/adi2axis_pkt.sv - ADC sample capture into AXI-Stream packets with sync arm, abort and overflow status
module adi2axis_pkt
  import adi2axis_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int CH_BYTES = 2,
  parameter  int FIFO_AW  = 6,
  localparam int DW       = calc_dw(NUM_CH, CH_BYTES),
  localparam int SW       = calc_sw(NUM_CH, CH_BYTES)
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESET,
  input  logic [DW-1:0] ddata,
  input  logic          dvalid,
  input  logic          dsync,
  output logic          ovf,
  input  logic          ctrl_start,
  input  logic          ctrl_stop,
  input  logic          cfg_sync_wait,
  input  logic [31:0]   cfg_num_beats,
  output logic          stat_busy,
  output logic          stat_done,
  output logic [31:0]   stat_beats,
  output logic          M_AXIS_TVALID,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic [SW-1:0] M_AXIS_TSTRB,
  output logic          M_AXIS_TLAST,
  input  logic          M_AXIS_TREADY
);

  localparam logic [DW-1:0] NULL_DATA = NULL_BEAT[DW-1:0];

  state_t        r_state;
  state_t        w_nxt;
  logic [31:0]   r_num_beats;
  logic [31:0]   r_captured;
  logic [31:0]   r_beats;
  logic          r_ovf;
  logic          r_abort;
  logic          r_last_sent;
  logic          r_hold;
  logic          r_hold_last;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;
  logic          w_hs;
  logic          w_cap_done;
  logic          w_cnt_last;
  logic          w_abort_last;
  logic          w_tlast;
  logic          w_done;
  logic [DW-1:0] w_dout;

  adi2axis_fifo #(
    .DW      (DW),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .i_clk (AXIS_ACLK),
    .i_rst (AXIS_ARESET),
    .wr_en (w_wr),
    .din   (ddata),
    .full  (w_full),
    .rd_en (w_rd),
    .dout  (w_dout),
    .empty (w_empty)
  );

  assign w_wr = dvalid && !w_full &&
                ((r_state == S_RUN) || (r_state == S_ARM && dsync && !ctrl_stop));
  assign w_cap_done = w_wr && (r_num_beats != 32'd0) && (r_captured + 32'd1 == r_num_beats);
  assign w_rd = M_AXIS_TREADY && !w_empty;
  assign w_hs = M_AXIS_TVALID && M_AXIS_TREADY;

  // No writes happen in DRAIN, so captured - handshaked is the buffer fill level there.
  assign w_cnt_last   = (r_num_beats != 32'd0) && (r_beats + 32'd1 == r_num_beats);
  assign w_abort_last = r_abort && (r_state == S_DRAIN) && (r_captured - r_beats == 32'd1);

  // A stalled beat keeps the TLAST it was first shown with; if that was 0 on
  // the final abort beat, the packet is closed by a null beat from TERM instead.
  always_comb begin
    w_tlast = 1'b0;
    if (r_state == S_TERM) begin
      w_tlast = 1'b1;
    end else if (!w_empty) begin
      w_tlast = r_hold ? r_hold_last : (w_cnt_last || w_abort_last);
    end
  end

  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_start) w_nxt = cfg_sync_wait ? S_ARM : S_RUN;
      end
      S_ARM: begin
        if (ctrl_stop)  w_nxt = S_IDLE;
        else if (w_wr)  w_nxt = w_cap_done ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (ctrl_stop || w_cap_done) w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty) begin
          if (r_last_sent) begin
            w_nxt  = S_IDLE;
            w_done = 1'b1;
          end else if (r_abort) begin
            w_nxt = (r_beats == 32'd0) ? S_IDLE : S_TERM;
          end
        end
      end
      S_TERM: begin
        if (M_AXIS_TREADY) begin
          w_nxt  = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_state     <= S_IDLE;
      r_num_beats <= '0;
      r_captured  <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_abort     <= 1'b0;
      r_last_sent <= 1'b0;
      r_hold      <= 1'b0;
      r_hold_last <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_hold      <= M_AXIS_TVALID && !M_AXIS_TREADY;
      r_hold_last <= w_tlast;
      if (r_state == S_IDLE && ctrl_start) begin
        r_num_beats <= cfg_num_beats;
        r_captured  <= '0;
        r_beats     <= '0;
        r_ovf       <= 1'b0;
        r_abort     <= 1'b0;
        r_last_sent <= 1'b0;
      end else begin
        if (w_wr) r_captured <= r_captured + 32'd1;
        if (w_hs) r_beats <= r_beats + 32'd1;
        if (r_state == S_RUN && dvalid && w_full) r_ovf <= 1'b1;
        if (r_state == S_RUN && ctrl_stop) r_abort <= 1'b1;
        if (w_hs && w_tlast) r_last_sent <= 1'b1;
      end
    end
  end

  assign M_AXIS_TVALID = !w_empty || (r_state == S_TERM);
  assign M_AXIS_TDATA  = w_empty ? NULL_DATA : w_dout;
  assign M_AXIS_TSTRB  = w_empty ? '0 : '1;
  assign M_AXIS_TLAST  = w_tlast;
  assign ovf           = r_ovf;
  assign stat_busy     = (r_state != S_IDLE);
  assign stat_done     = w_done;
  assign stat_beats    = r_beats;

endmodule

// File: tb/tb_adi2axis_pkt.sv
// tb/tb_adi2axis_pkt.sv - scoreboard bench for adi2axis_pkt
module tb_adi2axis_pkt;

  localparam int DW = 64;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] ddata = '0;
  logic          dvalid = 1'b0;
  logic          dsync = 1'b0;
  logic          ovf;
  logic          ctrl_start = 1'b0;
  logic          ctrl_stop = 1'b0;
  logic          cfg_sync_wait = 1'b0;
  logic [31:0]   cfg_num_beats = '0;
  logic          stat_busy;
  logic          stat_done;
  logic [31:0]   stat_beats;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic          tlast;
  logic          tready = 1'b0;

  adi2axis_pkt #(.NUM_CH(4), .CH_BYTES(2), .FIFO_AW(6)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .ddata         (ddata),
    .dvalid        (dvalid),
    .dsync         (dsync),
    .ovf           (ovf),
    .ctrl_start    (ctrl_start),
    .ctrl_stop     (ctrl_stop),
    .cfg_sync_wait (cfg_sync_wait),
    .cfg_num_beats (cfg_num_beats),
    .stat_busy     (stat_busy),
    .stat_done     (stat_done),
    .stat_beats    (stat_beats),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TSTRB  (tstrb),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int tlast_cyc = -1;
  logic [72:0]   exp_q[$];
  logic [72:0]   e_beat;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: stall stability and scoreboard pop on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!tvalid || tdata !== prev_data || tlast !== prev_last) begin
          n_fail++;
          $display("FAIL stall_stable t=%0t got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   $time, tvalid, tdata, tlast, prev_data, prev_last);
        end
      end
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat t=%0t got l=%b s=%h d=%h want no beat", $time, tlast, tstrb, tdata);
        end else begin
          e_beat = exp_q.pop_front();
          if ({tlast, tstrb, tdata} !== e_beat) begin
            n_fail++;
            $display("FAIL beat t=%0t got l=%b s=%h d=%h want l=%b s=%h d=%h", $time,
                     tlast, tstrb, tdata, e_beat[72], e_beat[71:64], e_beat[63:0]);
          end
        end
        if (tlast) tlast_cyc = cyc;
      end
      if (stat_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] nb, input logic sw);
    cfg_num_beats = nb;
    cfg_sync_wait = sw;
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
  endtask

  task automatic push_pkt(input int first, input int n, input logic last_on_end);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(last_on_end && i == n - 1), 8'hFF, DW'(first + i)});
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int i;
    i = 0;
    while (i < budget && done_cnt == d0) begin
      step();
      i++;
    end
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s_done_timeout got no stat_done want pulse within %0d cycles", tag, budget);
    end
  endtask

  task automatic end_scenario(input string tag);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_beats got %0d left want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({tvalid, tdata, tstrb, tlast, ovf, stat_busy, stat_done, stat_beats} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b d=%h s=%h l=%b ovf=%b busy=%b done=%b beats=%0d want all 0",
               tvalid, tdata, tstrb, tlast, ovf, stat_busy, stat_done, stat_beats);
    end
    rst = 1'b0;
    step(); step();
    n_checks++;
    if (tvalid !== 1'b0 || stat_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle got v=%b busy=%b want 0 0", tvalid, stat_busy);
    end
  endtask

  task automatic test_basic_packet();
    int d0;
    d0 = done_cnt;
    tready = 1'b1;
    push_pkt(0, 8, 1'b1);
    pulse_start(32'd8, 1'b0);
    for (int k = 0; k < 12; k++) begin
      ddata = DW'(k);
      dvalid = 1'b1;
      step();
    end
    dvalid = 1'b0;
    wait_done("basic", d0, 50);
    n_checks++;
    if (stat_beats !== 32'd8) begin
      n_fail++;
      $display("FAIL basic_stat_beats got %0d want 8", stat_beats);
    end
    n_checks++;
    if (done_cyc != tlast_cyc + 1) begin
      n_fail++;
      $display("FAIL basic_done_timing got cycle %0d want %0d", done_cyc, tlast_cyc + 1);
    end
    step(); step(); step();
    n_checks++;
    if (done_cnt != d0 + 1 || stat_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_single_done got %0d pulses busy=%b want 1 pulse busy=0", done_cnt - d0, stat_busy);
    end
    end_scenario("basic");
  endtask

  task automatic test_sync_wait();
    int d0;
    d0 = done_cnt;
    tready = 1'b1;
    push_pkt(4, 4, 1'b1);
    pulse_start(32'd4, 1'b1);
    for (int k = 0; k < 12; k++) begin
      ddata = DW'(k);
      dvalid = 1'b1;
      dsync = (k == 4);
      step();
      if (k == 3) begin
        n_checks++;
        if (tvalid !== 1'b0 || stat_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL sync_armed got v=%b busy=%b want 0 1", tvalid, stat_busy);
        end
      end
    end
    dvalid = 1'b0;
    dsync = 1'b0;
    wait_done("sync", d0, 50);
    n_checks++;
    if (stat_beats !== 32'd4) begin
      n_fail++;
      $display("FAIL sync_stat_beats got %0d want 4", stat_beats);
    end
    end_scenario("sync");
  endtask

  task automatic test_continuous_stop();
    int d0;
    d0 = done_cnt;
    tready = 1'b1;
    push_pkt(100, 20, 1'b0);
    exp_q.push_back({1'b1, 8'h00, 64'h0});
    pulse_start(32'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      ddata = DW'(100 + k);
      dvalid = 1'b1;
      step();
    end
    dvalid = 1'b0;
    step(); step(); step();
    n_checks++;
    if (tvalid !== 1'b0 || stat_busy !== 1'b1 || stat_beats !== 32'd20) begin
      n_fail++;
      $display("FAIL cont_running got v=%b busy=%b beats=%0d want 0 1 20", tvalid, stat_busy, stat_beats);
    end
    ctrl_stop = 1'b1;
    step();
    ctrl_stop = 1'b0;
    wait_done("cont", d0, 20);
    n_checks++;
    if (stat_beats !== 32'd21) begin
      n_fail++;
      $display("FAIL cont_stat_beats got %0d want 21", stat_beats);
    end
    end_scenario("cont");
  endtask

  task automatic test_overflow();
    int d0;
    d0 = done_cnt;
    tready = 1'b0;
    push_pkt(0, 64, 1'b1);
    pulse_start(32'd0, 1'b0);
    for (int k = 0; k < 70; k++) begin
      ddata = DW'(k);
      dvalid = 1'b1;
      step();
      if (k == 63 || k == 64) begin
        n_checks++;
        if (ovf !== (k == 64)) begin
          n_fail++;
          $display("FAIL ovf_after_sample_%0d got %b want %b", k + 1, ovf, (k == 64));
        end
      end
    end
    dvalid = 1'b0;
    ctrl_stop = 1'b1;
    step();
    ctrl_stop = 1'b0;
    step(); step();
    tready = 1'b1;
    wait_done("ovf", d0, 200);
    n_checks++;
    if (ovf !== 1'b1 || stat_beats !== 32'd64) begin
      n_fail++;
      $display("FAIL ovf_hold got ovf=%b beats=%0d want 1 64", ovf, stat_beats);
    end
    end_scenario("ovf");
    d0 = done_cnt;
    pulse_start(32'd0, 1'b1);
    n_checks++;
    if (ovf !== 1'b0 || stat_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_clear_on_start got ovf=%b busy=%b want 0 1", ovf, stat_busy);
    end
    ctrl_stop = 1'b1;
    step();
    ctrl_stop = 1'b0;
    step(); step();
    n_checks++;
    if (stat_busy !== 1'b0 || tvalid !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL arm_abort got busy=%b v=%b done=%0d want 0 0 0", stat_busy, tvalid, done_cnt - d0);
    end
  endtask

  task automatic test_random_ready();
    int d0;
    int i;
    d0 = done_cnt;
    push_pkt(0, 16, 1'b1);
    pulse_start(32'd16, 1'b0);
    i = 0;
    while (i < 400 && done_cnt == d0) begin
      tready = 1'($urandom_range(0, 1));
      dvalid = (i < 30);
      ddata = DW'(i);
      step();
      i++;
    end
    dvalid = 1'b0;
    tready = 1'b1;
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL rand_done_timeout got no stat_done want pulse within 400 cycles");
    end
    n_checks++;
    if (stat_beats !== 32'd16) begin
      n_fail++;
      $display("FAIL rand_stat_beats got %0d want 16", stat_beats);
    end
    end_scenario("rand");
  endtask

  task automatic test_reset_mid_packet();
    int d0;
    tready = 1'b0;
    pulse_start(32'd0, 1'b0);
    for (int k = 0; k < 66; k++) begin
      ddata = DW'(k);
      dvalid = 1'b1;
      step();
    end
    dvalid = 1'b0;
    n_checks++;
    if (ovf !== 1'b1 || tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre got ovf=%b v=%b want 1 1", ovf, tvalid);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || stat_busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async got v=%b busy=%b ovf=%b want 0 0 0", tvalid, stat_busy, ovf);
    end
    step(); step();
    rst = 1'b0;
    step();
    d0 = done_cnt;
    tready = 1'b1;
    push_pkt(200, 8, 1'b1);
    pulse_start(32'd8, 1'b0);
    for (int k = 0; k < 10; k++) begin
      ddata = DW'(200 + k);
      dvalid = 1'b1;
      step();
    end
    dvalid = 1'b0;
    wait_done("rst", d0, 50);
    n_checks++;
    if (stat_beats !== 32'd8 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fresh_packet got beats=%0d ovf=%b want 8 0", stat_beats, ovf);
    end
    end_scenario("rst");
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_sync_wait();
    test_continuous_stop();
    test_overflow();
    test_random_ready();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no end of test want finish before 500000");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/adi2axis_pkt.md
Name: adi2axis_pkt

Overview:
Parametrised successor of the ADI-FIFO-to-AXI-Stream converter. Captures multi-channel ADC samples (ddata/dvalid/dsync) into an internal FWFT buffer and emits them as AXI-Stream packets of a programmable beat count, or as one continuous stream. It adds sync-armed start, software abort with clean TLAST termination, sticky overflow and capture status. Sits between the ADC core FIFO port and a DMA S2MM stream; the AXI-Lite register file drives the cfg_/ctrl_ inputs directly.

Parameters:
NUM_CH, 4, number of ADC channels packed per beat
CH_BYTES, 2, bytes per channel sample
FIFO_AW, 6, log2 buffer depth (64 beats)
(derived: DW = NUM_CH*CH_BYTES*8, SW = NUM_CH*CH_BYTES)

Ports:
AXIS_ACLK  in  1  sole clock
AXIS_ARESET  in  1  asynchronous, active-high reset
ddata  in  DW  ADC sample word, channel 0 in LSBs
dvalid  in  1  ddata qualifier
dsync  in  1  ADC sync marker, qualified by dvalid
ovf  out  1  sticky: a sample was dropped on a full buffer
ctrl_start  in  1  1-cycle pulse: begin capture
ctrl_stop  in  1  1-cycle pulse: abort capture
cfg_sync_wait  in  1  1 = first captured sample is one with dsync=1
cfg_num_beats  in  32  beats per packet; 0 = continuous
stat_busy  out  1  state != IDLE
stat_done  out  1  1-cycle pulse on completion
stat_beats  out  32  beats handshaked on M_AXIS in the current/last packet
M_AXIS_TVALID  out  1
M_AXIS_TDATA  out  DW
M_AXIS_TSTRB  out  SW
M_AXIS_TLAST  out  1
M_AXIS_TREADY  in  1

Behaviour:
- Reset: all outputs 0, state IDLE, buffer empty, counters 0, ovf 0.
- States: IDLE, ARM, RUN, DRAIN, TERM.
- IDLE: ctrl_start -> ARM when cfg_sync_wait=1, else RUN; clears ovf, stat_beats and the capture counter; latches cfg_num_beats and cfg_sync_wait. ctrl_stop in IDLE is ignored.
- ARM: the first dvalid&dsync sample is written and the state moves to RUN in the same cycle. All other samples are discarded. ctrl_stop -> IDLE with no output and no stat_done.
- RUN: each dvalid sample is written when the buffer is not full. On full, the sample is dropped and ovf is set (sticky until the next start). Only written samples count. When captured == num_beats (num_beats != 0), capture ends -> DRAIN. ctrl_stop -> DRAIN. Both in the same cycle: the sample that completes the count is still written.
- DRAIN: no writes.
  - Buffer empties with last handshake done and TLAST already sent -> IDLE, pulse stat_done.
  - On abort with no beats handshaked and buffer empty -> IDLE, no stat_done.
  - On abort after at least one beat was sent and TLAST not yet sent -> the final buffered beat carries TLAST. If the buffer is already empty -> TERM.
- TERM: drive one null beat (TDATA=0, TSTRB=0, TLAST=1). On handshake -> IDLE, pulse stat_done.
- Output: FWFT buffer head drives TDATA. TVALID = !empty or TERM. TSTRB = all ones on data beats. TLAST=1 on beat num_beats and on the final abort beat. A beat presented with TVALID stays stable until TREADY; TVALID never drops without a handshake.
- Latency: a sample written in cycle N is visible on TDATA in cycle N+1 when the buffer was empty.
- Simultaneous write and read on a full buffer is allowed: full blocks the write (ovf set), the read proceeds.
- stat_beats increments on every TVALID&TREADY, null beat included. The counter is 32-bit and wraps in continuous mode. Continuous mode ends only via ctrl_stop.
- ctrl_start outside IDLE is ignored.
- Asynchronous reset mid-packet flushes immediately. No TLAST is emitted; the downstream DMA must be reset alongside.

Decomposition:
- Package adi2axis_pkg: state enum, DW/SW width functions, NULL_BEAT constant.
- Sub-module adi2axis_fifo: single-clock FWFT FIFO with parameters DW and FIFO_AW and ports wr_en, din, full, rd_en, dout, empty, with async active-high reset.
- FSM, counters and TLAST logic stay in the top.

Test Plan:
- NUM_CH=4, CH_BYTES=2, num_beats=8, sync_wait=0, TREADY=1, dvalid every cycle -> exactly 8 beats, TLAST on beat 8, TSTRB=0xFF, stat_done one cycle later, stat_beats=8.
- sync_wait=1, dsync asserted on sample 5 of a ramp 0,1,2,... -> first TDATA=4, packet of num_beats=4 carries 4..7.
- num_beats=0, TREADY=1, stream 20 beats, ctrl_stop while buffer empty -> 20 data beats without TLAST, then a null beat (TSTRB=0, TLAST=1), stat_beats=21.
- TREADY=0 for 70 cycles with dvalid every cycle, FIFO_AW=6 -> ovf=1 after sample 65, exactly 64 beats output in order once TREADY=1, ovf held until next ctrl_start.
- num_beats=16, random TREADY (~50%) -> TDATA/TLAST stable across every stall, 16 beats, data order matches the input ramp.
- AXIS_ARESET asserted mid-packet -> TVALID, stat_busy and ovf go to 0 immediately. A following ctrl_start produces a fresh full packet.
